// File: rtl/cpu_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cpu_pkg: opcodes, sequencer states and instruction classes for the control unit
// Revision: 1.0
// ----------------------------------------------------------------------------
package cpu_pkg;

  localparam int              OPW     = 5;
  localparam logic [OPW-1:0]  ALU_ADD = 5'b00011;

  localparam logic [OPW-1:0] OP_LD   = 5'd0;
  localparam logic [OPW-1:0] OP_LDI  = 5'd1;
  localparam logic [OPW-1:0] OP_ST   = 5'd2;
  localparam logic [OPW-1:0] OP_ADD  = 5'd3;
  localparam logic [OPW-1:0] OP_SUB  = 5'd4;
  localparam logic [OPW-1:0] OP_SHR  = 5'd5;
  localparam logic [OPW-1:0] OP_SHRA = 5'd6;
  localparam logic [OPW-1:0] OP_SHL  = 5'd7;
  localparam logic [OPW-1:0] OP_ROR  = 5'd8;
  localparam logic [OPW-1:0] OP_ROL  = 5'd9;
  localparam logic [OPW-1:0] OP_AND  = 5'd10;
  localparam logic [OPW-1:0] OP_OR   = 5'd11;
  localparam logic [OPW-1:0] OP_ADDI = 5'd12;
  localparam logic [OPW-1:0] OP_ANDI = 5'd13;
  localparam logic [OPW-1:0] OP_ORI  = 5'd14;
  localparam logic [OPW-1:0] OP_MUL  = 5'd15;
  localparam logic [OPW-1:0] OP_DIV  = 5'd16;
  localparam logic [OPW-1:0] OP_NEG  = 5'd17;
  localparam logic [OPW-1:0] OP_NOT  = 5'd18;
  localparam logic [OPW-1:0] OP_BR   = 5'd19;
  localparam logic [OPW-1:0] OP_JR   = 5'd20;
  localparam logic [OPW-1:0] OP_JAL  = 5'd21;
  localparam logic [OPW-1:0] OP_IN   = 5'd22;
  localparam logic [OPW-1:0] OP_OUT  = 5'd23;
  localparam logic [OPW-1:0] OP_MFHI = 5'd24;
  localparam logic [OPW-1:0] OP_MFLO = 5'd25;
  localparam logic [OPW-1:0] OP_NOP  = 5'd26;
  localparam logic [OPW-1:0] OP_HALT = 5'd27;

  typedef enum logic [3:0] {
    S_RESET = 4'd0,
    S_T0    = 4'd1,
    S_T1    = 4'd2,
    S_T2    = 4'd3,
    S_T3    = 4'd4,
    S_T4    = 4'd5,
    S_T5    = 4'd6,
    S_T6    = 4'd7,
    S_T7    = 4'd8,
    S_HALT  = 4'd9
  } state_t;

  typedef enum logic [3:0] {
    C_ALU3, C_ALUI, C_UNARY, C_MULDIV, C_LD, C_LDI, C_ST, C_BR,
    C_JR, C_JAL, C_IN, C_OUT, C_MFHI, C_MFLO, C_NOP, C_HALT
  } iclass_t;

  // Final execute state of each class; execute states are consecutive from T3.
  function automatic state_t last_state(input iclass_t c);
    state_t s;
    case (c)
      C_ALU3, C_ALUI, C_LDI: s = S_T5;
      C_UNARY, C_JAL:        s = S_T4;
      C_MULDIV, C_BR:        s = S_T6;
      C_LD, C_ST:            s = S_T7;
      default:               s = S_T3;
    endcase
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/opcode_classify.sv
`default_nettype none
// ----------------------------------------------------------------------------
// opcode_classify: maps a 5-bit opcode onto its execute-sequence class
// Revision: 1.0
// ----------------------------------------------------------------------------
module opcode_classify
  import cpu_pkg::*;
(
  input  logic [OPW-1:0] opcode,
  output iclass_t        iclass
);

  always_comb begin
    iclass = C_NOP;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
      OP_ROL, OP_SHR, OP_SHRA, OP_SHL:      iclass = C_ALU3;
      OP_ADDI, OP_ANDI, OP_ORI:             iclass = C_ALUI;
      OP_NEG, OP_NOT:                       iclass = C_UNARY;
      OP_MUL, OP_DIV:                       iclass = C_MULDIV;
      OP_LD:                                iclass = C_LD;
      OP_LDI:                               iclass = C_LDI;
      OP_ST:                                iclass = C_ST;
      OP_BR:                                iclass = C_BR;
      OP_JR:                                iclass = C_JR;
      OP_JAL:                               iclass = C_JAL;
      OP_IN:                                iclass = C_IN;
      OP_OUT:                               iclass = C_OUT;
      OP_MFHI:                              iclass = C_MFHI;
      OP_MFLO:                              iclass = C_MFLO;
      OP_HALT:                              iclass = C_HALT;
      default:                              iclass = C_NOP;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/control_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// control_sequencer: hardwired Moore control unit driving the 32-bit datapath
// Revision: 1.0
// ----------------------------------------------------------------------------
module control_sequencer
  import cpu_pkg::*;
(
  input  logic           clk,
  input  logic           clr,
  input  logic [31:0]    ir,
  input  logic           con_ff,
  input  logic           stop,
  output logic           run,
  output logic [OPW-1:0] alu_op,
  output logic           PCout, ZHighout, ZLowout, MDRout, InPortout,
  output logic           HIout, LOout, BAout, Cout, Rout,
  output logic           PCin, IRin, MARin, MDRin, Yin, ZHighIn,
  output logic           ZLowIn, HIin, LOin, Rin, CONin, OutPort_enable,
  output logic           Gra, Grb, Grc,
  output logic           IncPC, Read, ramWE,
  output logic           R15_force
);

  state_t         r_state;
  state_t         w_next;
  logic [OPW-1:0] r_opcode;
  logic           r_stop_pend;
  iclass_t        w_class;
  logic           w_last;
  logic           w_unused_ir;

  assign w_unused_ir = ^ir[31-OPW:0];
  assign w_last      = (r_state == last_state(w_class));

  opcode_classify u_classify (
    .opcode (r_opcode),
    .iclass (w_class)
  );

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state     <= S_RESET;
      r_opcode    <= '0;
      r_stop_pend <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_T2)
        r_opcode <= ir[31:32-OPW];
      // A stop seen early is held until the instruction's last cycle.
      if (w_next == S_HALT)
        r_stop_pend <= 1'b0;
      else if (stop && r_state != S_HALT)
        r_stop_pend <= 1'b1;
    end
  end

  always_comb begin
    w_next = r_state;
    run = 1'b1; alu_op = '0;
    PCout = 1'b0; ZHighout = 1'b0; ZLowout = 1'b0; MDRout = 1'b0; InPortout = 1'b0;
    HIout = 1'b0; LOout = 1'b0; BAout = 1'b0; Cout = 1'b0; Rout = 1'b0;
    PCin = 1'b0; IRin = 1'b0; MARin = 1'b0; MDRin = 1'b0; Yin = 1'b0; ZHighIn = 1'b0;
    ZLowIn = 1'b0; HIin = 1'b0; LOin = 1'b0; Rin = 1'b0; CONin = 1'b0; OutPort_enable = 1'b0;
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0;
    IncPC = 1'b0; Read = 1'b0; ramWE = 1'b0; R15_force = 1'b0;

    case (r_state)
      S_RESET: w_next = S_T0;
      S_T0: begin
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; ZLowIn = 1'b1; alu_op = ALU_ADD;
        w_next = S_T1;
      end
      S_T1: begin
        ZLowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
        w_next = S_T2;
      end
      S_T2: begin
        MDRout = 1'b1; IRin = 1'b1;
        w_next = S_T3;
      end
      S_HALT: begin
        run    = 1'b0;
        w_next = S_HALT;
      end
      default: begin
        if (w_class == C_HALT)
          w_next = S_HALT;
        else if (w_last)
          w_next = (stop || r_stop_pend) ? S_HALT : S_T0;
        else
          w_next = state_t'(r_state + 4'd1);

        case (r_state)
          S_T3: begin
            case (w_class)
              C_ALU3, C_ALUI: begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
              C_UNARY: begin Grb = 1'b1; Rout = 1'b1; alu_op = r_opcode; ZLowIn = 1'b1; end
              C_MULDIV: begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
              C_LD, C_LDI, C_ST: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
              C_BR: begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
              C_JR: begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
              C_JAL: begin PCout = 1'b1; R15_force = 1'b1; Rin = 1'b1; end
              C_IN: begin InPortout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
              C_OUT: begin Gra = 1'b1; Rout = 1'b1; OutPort_enable = 1'b1; end
              C_MFHI: begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
              C_MFLO: begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
              default: ;
            endcase
          end
          S_T4: begin
            case (w_class)
              C_ALU3: begin Grc = 1'b1; Rout = 1'b1; alu_op = r_opcode; ZLowIn = 1'b1; end
              C_ALUI: begin Cout = 1'b1; alu_op = r_opcode; ZLowIn = 1'b1; end
              C_UNARY: begin ZLowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
              C_MULDIV: begin
                Grb = 1'b1; Rout = 1'b1; alu_op = r_opcode; ZHighIn = 1'b1; ZLowIn = 1'b1;
              end
              C_LD, C_LDI, C_ST: begin Cout = 1'b1; alu_op = ALU_ADD; ZLowIn = 1'b1; end
              C_BR: begin PCout = 1'b1; Yin = 1'b1; end
              C_JAL: begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
              default: ;
            endcase
          end
          S_T5: begin
            case (w_class)
              C_ALU3, C_ALUI, C_LDI: begin ZLowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
              C_MULDIV: begin ZLowout = 1'b1; LOin = 1'b1; end
              C_LD, C_ST: begin ZLowout = 1'b1; MARin = 1'b1; end
              C_BR: begin Cout = 1'b1; alu_op = ALU_ADD; ZLowIn = 1'b1; end
              default: ;
            endcase
          end
          S_T6: begin
            case (w_class)
              C_MULDIV: begin ZHighout = 1'b1; HIin = 1'b1; end
              C_LD: begin Read = 1'b1; MDRin = 1'b1; end
              C_ST: begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
              // Not-taken branch still spends the cycle, with every strobe idle.
              C_BR: begin ZLowout = con_ff; PCin = con_ff; end
              default: ;
            endcase
          end
          S_T7: begin
            case (w_class)
              C_LD: begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
              C_ST: ramWE = 1'b1;
              default: ;
            endcase
          end
          default: ;
        endcase
      end
    endcase
  end

endmodule
`default_nettype wire
